// File: rtl/ascii_entry_ctrl_if.sv
// ascii_entry_ctrl_if: keystroke input channel and committed-number output channel
interface ascii_entry_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                  ascii_valid;
  logic [11:0]           ascii_in;
  logic                  ascii_ready;
  logic                  num_valid;
  logic                  num_ready;
  logic [DATA_WIDTH-1:0] num_out;
  modport master (output ascii_valid, ascii_in, num_ready, input ascii_ready, num_valid, num_out);
  modport slave  (input ascii_valid, ascii_in, num_ready, output ascii_ready, num_valid, num_out);
endinterface

// File: rtl/ascii_entry_ctrl.sv
// ascii_entry_ctrl: accumulates ASCII digits into a decimal number and commits it over valid/ready.
// Define ASCII_ENTRY_NEG_EN to accept a leading '-' and commit the two's complement.
module ascii_entry_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIGITS = 9,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ascii_entry_ctrl_if.slave     bus,
  output logic [DATA_WIDTH-1:0] partial_value,
  output logic [CNT_WIDTH-1:0]  digit_count,
  output logic                  overflow_pulse
);
`ifdef ASCII_ENTRY_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif
  localparam logic [CNT_WIDTH-1:0] MAXC = CNT_WIDTH'(MAX_DIGITS);
  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] partial_q, partial_d, num_out_q, num_out_d, mul10, dig_ext, commit_val;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  num_valid_q, num_valid_d, ovf_q, ovf_d, neg_q, neg_d;
  logic                  acc, is_dig, is_ent, is_bs, is_esc, is_neg;
  assign bus.ascii_ready = state_q != HOLD;
  assign acc    = bus.ascii_valid && bus.ascii_ready;
  assign is_dig = bus.ascii_in >= 12'd48 && bus.ascii_in <= 12'd57;
  assign is_ent = bus.ascii_in == 12'd13;
  assign is_bs  = bus.ascii_in == 12'd8;
  assign is_esc = bus.ascii_in == 12'd27;
  assign is_neg = NEG_EN && bus.ascii_in == 12'd45;
  // digit codes 0x30..0x39 carry their value in the low nibble
  assign dig_ext    = {{(DATA_WIDTH-4){1'b0}}, bus.ascii_in[3:0]};
  assign mul10      = (partial_q << 3) + (partial_q << 1);
  assign commit_val = neg_q ? ~partial_q + DATA_WIDTH'(1) : partial_q;
  always_comb begin
    state_d     = state_q;
    partial_d   = partial_q;
    count_d     = count_q;
    num_out_d   = num_out_q;
    num_valid_d = num_valid_q;
    neg_d       = neg_q;
    ovf_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && is_dig) begin
          partial_d = dig_ext;
          count_d   = CNT_WIDTH'(1);
          state_d   = ENTRY;
        end else if (acc && is_neg) begin
          neg_d     = 1'b1;
          partial_d = '0;
          count_d   = '0;
          state_d   = ENTRY;
        end
      end
      ENTRY: begin
        if (acc && is_dig) begin
          if (count_q < MAXC) begin
            partial_d = mul10 + dig_ext;
            count_d   = count_q + CNT_WIDTH'(1);
          end else ovf_d = 1'b1;
        end else if (acc && is_bs) begin
          if (count_q == '0) begin
            neg_d   = 1'b0;
            state_d = IDLE;
          end else begin
            partial_d = partial_q / DATA_WIDTH'(10);
            count_d   = count_q - CNT_WIDTH'(1);
            // a lone '-' keeps the entry open after its last digit is erased
            if (count_q == CNT_WIDTH'(1) && !neg_q) begin
              partial_d = '0;
              state_d   = IDLE;
            end
          end
        end else if (acc && is_esc) begin
          partial_d = '0;
          count_d   = '0;
          neg_d     = 1'b0;
          state_d   = IDLE;
        end else if (acc && is_ent && !(neg_q && count_q == '0)) begin
          num_out_d   = commit_val;
          num_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.num_ready) begin
          num_valid_d = 1'b0;
          partial_d   = '0;
          count_d     = '0;
          neg_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      partial_q   <= '0;
      count_q     <= '0;
      num_out_q   <= '0;
      num_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      partial_q   <= partial_d;
      count_q     <= count_d;
      num_out_q   <= num_out_d;
      num_valid_q <= num_valid_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
    end
  end
  assign bus.num_valid   = num_valid_q;
  assign bus.num_out     = num_out_q;
  assign partial_value   = partial_q;
  assign digit_count     = count_q;
  assign overflow_pulse  = ovf_q;
endmodule

// File: doc/ascii_entry_ctrl.md
Name: ascii_entry_ctrl

Overview:
- Sequences a stream of ASCII keystrokes into multi-digit unsigned decimal numbers for the CPU.
- Digits accumulate as value = value*10 + digit. Backspace, escape and enter edit, clear or commit the entry.
- A committed number is presented to the CPU-side consumer over a valid/ready handshake.
- Sits between the keyboard/ASCII source and the processor's input register or memory-mapped port.

Parameters:
- DATA_WIDTH, 32, width of accumulator and committed number.
- MAX_DIGITS, 9, maximum digits per entry. Must satisfy 10^MAX_DIGITS - 1 < 2^DATA_WIDTH. Default 999,999,999 fits in 32 bits.
- CNT_WIDTH, 4, width of digit counter. Must hold MAX_DIGITS.

Ports:
- clock, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, synchronous active-high reset.
- ascii_valid, input, 1, ascii_in holds a keystroke.
- ascii_in, input, 12, ASCII code, zero-extended.
- ascii_ready, output, 1, block can accept a keystroke this cycle.
- num_valid, output, 1, committed number available on num_out.
- num_ready, input, 1, consumer accepts num_out.
- num_out, output, DATA_WIDTH, committed number.
- partial_value, output, DATA_WIDTH, current accumulator, for display.
- digit_count, output, CNT_WIDTH, digits currently entered.
- overflow_pulse, output, 1, one-cycle pulse when a digit is rejected because MAX_DIGITS is reached.

Behaviour:
- Clock and reset: one clock, named clock; reset named reset, synchronous and active-high.
- Reset values: state=IDLE; partial_value=0; digit_count=0; num_out=0; num_valid=0; overflow_pulse=0; ascii_ready=1. Reset wins over every other event in the same cycle, including mid-entry and a pending num_valid.
- Key acceptance: a key is accepted only on a cycle where ascii_valid && ascii_ready. ascii_ready = (state != HOLD), combinational from state.
- Key classes:
  - digit: 48..57, value = code-48.
  - enter: 13.
  - backspace: 8.
  - escape: 27.
  - anything else: accepted and ignored, no state change.
- States: IDLE, ENTRY, HOLD.
- IDLE:
  - digit: partial=d, count=1, go to ENTRY.
  - enter, backspace, escape: ignored; stay in IDLE, no output.
- ENTRY:
  - digit with count<MAX_DIGITS: partial = partial*10 + d, truncated to DATA_WIDTH; count+1.
  - digit with count==MAX_DIGITS: digit dropped; partial unchanged; overflow_pulse=1 on the next cycle only.
  - backspace: partial = partial/10 (integer); count-1. If count becomes 0, go to IDLE with partial=0.
  - escape: partial=0, count=0, go to IDLE.
  - enter: num_out=partial, num_valid=1, go to HOLD. partial and count stay visible.
- HOLD:
  - num_valid held high; num_out stable.
  - On num_valid && num_ready: next cycle num_valid=0, partial=0, count=0, state=IDLE, ascii_ready=1.
  - Keys are not accepted (ascii_ready=0); upstream must hold them.
- Latency:
  - Accepted key updates partial_value and digit_count at the same edge; visible the next cycle.
  - Enter accepted at edge N gives num_valid=1 from edge N.
  - Minimum one cycle in HOLD even if num_ready is already high.
- Leading zeros: "0","0","7" yields 7 with digit_count=3. Leading zeros count toward MAX_DIGITS.
- Arithmetic: multiply-by-10 implemented as (x<<3)+(x<<1); no signed arithmetic.

Optional Feature:
- Macro: ASCII_ENTRY_NEG_EN.
- Defined:
  - '-' (45) accepted in IDLE sets a neg flag and moves to ENTRY with count=0.
  - Backspace with neg set and count=0 clears neg and returns to IDLE.
  - Enter with count=0 and neg set is ignored.
  - On commit, num_out = two's complement of partial when neg is set.
  - neg cleared on handshake, escape and reset.
- Not defined: '-' is an ignored character; num_out is always unsigned.

Test Plan:
- Reset, then keys '4','2',13 with num_ready=0 -> partial 4 then 42; num_valid=1, num_out=42, ascii_ready=0. Raise num_ready -> next cycle num_valid=0, partial=0, count=0.
- Keys '1','2','3',8,'9',13 -> partial goes 1,12,123,12,129; num_out=129.
- Ten keys '9' with MAX_DIGITS=9 -> partial=999999999, count=9; overflow_pulse high exactly one cycle after the 10th key.
- Keys 13, 8, 'A' from IDLE -> no num_valid; all outputs remain 0; each key consumed.
- Keys '5', 27, '6', 13 -> num_out=6. Also: assert reset during HOLD with num_valid=1 -> num_valid=0, state IDLE next cycle.
- With ASCII_ENTRY_NEG_EN: keys '-','1','5',13 -> num_out=32'hFFFFFFF1. Without the macro, the same keys -> num_out=15.
